// File: rtl/vga_src_arbiter.sv
// Frame-synchronous arbiter that shares one VGA output between two pixel sources.
// Ownership moves only on the current owner's vsync assertion, after a minimum tenure under contention.
module vga_src_arbiter #(
  parameter int unsigned RGB_W        = 8,
  parameter int unsigned MIN_FRAMES   = 2,
  parameter bit          SYNC_ACT_LOW = 1'b1,
  parameter bit          DEFAULT_SRC  = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             pix_en_i,
  input  logic [1:0]       req_i,
  input  logic             h1_i,
  input  logic             v1_i,
  input  logic [RGB_W-1:0] rgb1_i,
  input  logic             h2_i,
  input  logic             v2_i,
  input  logic [RGB_W-1:0] rgb2_i,
  output logic [RGB_W-1:0] rgb_o,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic [1:0]       gnt_o,
  output logic             sel_o,
  output logic             busy_o,
  output logic             frame_start_o
);

  localparam int unsigned    CNT_W     = 4;
  localparam logic           SYNC_ACT  = SYNC_ACT_LOW ? 1'b0 : 1'b1;
  localparam logic           SYNC_IDLE = ~SYNC_ACT;
  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_FRAMES);
  localparam logic [1:0]     GNT_RST   = DEFAULT_SRC ? 2'b10 : 2'b01;

  typedef enum logic {ST_OWN, ST_PEND} state_e;

  state_e             state_q, state_d;
  logic               sel_q, sel_d;
  logic [1:0]         gnt_q, gnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               vs_prev_q, vs_prev_d;
  logic               busy_q, busy_d;
  logic               fs_q, fs_d;
  logic [RGB_W-1:0]   rgb_q, rgb_d;
  logic               hs_q, hs_d;
  logic               vs_q, vs_d;

  logic other_c, vs_act_c, vs_other_act_c, frame_start_c, sw_ok_c;

  // Owner frame edge and switch eligibility
  always_comb begin
    other_c        = ~sel_q;
    vs_act_c       = ((sel_q ? v2_i : v1_i) == SYNC_ACT);
    vs_other_act_c = ((other_c ? v2_i : v1_i) == SYNC_ACT);
    frame_start_c  = pix_en_i & vs_act_c & ~vs_prev_q;
    sw_ok_c        = req_i[other_c] & (~req_i[sel_q] | (cnt_q >= MIN_CNT));
  end

  // Next-state: datapath capture, tenure counting and ownership FSM
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    vs_prev_d = vs_prev_q;
    rgb_d     = rgb_q;
    hs_d      = hs_q;
    vs_d      = vs_q;
    fs_d      = 1'b0;
    if (pix_en_i) begin
      rgb_d     = sel_q ? rgb2_i : rgb1_i;
      hs_d      = sel_q ? h2_i : h1_i;
      vs_d      = sel_q ? v2_i : v1_i;
      fs_d      = frame_start_c;
      vs_prev_d = vs_act_c;
      case (state_q)
        ST_OWN: begin
          if (frame_start_c && (cnt_q < MIN_CNT)) cnt_d = cnt_q + CNT_W'(1);
          if (sw_ok_c) state_d = ST_PEND;
        end
        ST_PEND: begin
          if (!req_i[other_c]) begin
            state_d = ST_OWN;
          end else if (frame_start_c) begin
            // New owner's current vsync level seeds edge detection to avoid a false edge
            state_d   = ST_OWN;
            sel_d     = other_c;
            cnt_d     = '0;
            vs_prev_d = vs_other_act_c;
          end
        end
        default: state_d = ST_OWN;
      endcase
    end
    busy_d = (state_d == ST_PEND);
    gnt_d  = sel_d ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_OWN;
      sel_q     <= DEFAULT_SRC;
      gnt_q     <= GNT_RST;
      cnt_q     <= '0;
      vs_prev_q <= 1'b0;
      busy_q    <= 1'b0;
      fs_q      <= 1'b0;
      rgb_q     <= '0;
      hs_q      <= SYNC_IDLE;
      vs_q      <= SYNC_IDLE;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      gnt_q     <= gnt_d;
      cnt_q     <= cnt_d;
      vs_prev_q <= vs_prev_d;
      busy_q    <= busy_d;
      fs_q      <= fs_d;
      rgb_q     <= rgb_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
    end
  end

  assign rgb_o         = rgb_q;
  assign hsync_o       = hs_q;
  assign vsync_o       = vs_q;
  assign gnt_o         = gnt_q;
  assign sel_o         = sel_q;
  assign busy_o        = busy_q;
  assign frame_start_o = fs_q;

endmodule
